track_pos_filter: RTL and testbench
===================================

Name: track_pos_filter

Overview:
- Conditions raw blob-centroid coordinates from the camera capture path into stable display coordinates for the game VGA path.
- Per accepted sample: boxcar moving average over 2^LOG2_WIN samples, outlier rejection, loss-of-target timeout, then scale, mirror and clamp to the display raster.
- Sits between capture (PCLK domain, already synchronised upstream) and the 108 MHz game logic.
- Replaces the fixed single-register smoothing and hard-coded 1280/320 and 1024/240 scaling.

Parameters:
- IN_W, 9: source coordinate width.
- OUT_W, 12: display coordinate width.
- LOG2_WIN, 4: averaging window is 2^LOG2_WIN samples; legal range 0..6.
- X_MUL, 4 and X_SHIFT, 0: x scale = X_MUL / 2^X_SHIFT.
- Y_MUL, 273 and Y_SHIFT, 6: y scale is approximately 4.266.
- X_DST, 1280 and Y_DST, 1024: display extent; outputs are clamped to DST-1.
- MIRROR_X, 1: when 1, out_x = (X_DST-1) - scaled_x, floored at 0.
- JUMP_MAX, 40: maximum per-axis deviation from the current average, in source pixels.
- REJECT_LIMIT, 8: consecutive rejects that force re-acquire.
- LOST_TIMEOUT, 2500000: cycles without a found sample before lost is raised.

Ports:
- clk, input, 1: sole clock.
- resetn, input, 1: asynchronous active-low reset.
- in_valid, input, 1: one-cycle sample strobe.
- in_found, input, 1: sample contains a target; qualified by in_valid.
- in_x, input, IN_W: raw x.
- in_y, input, IN_W: raw y.
- avg_en, input, 1: 1 = averaged mode, 0 = pass-through.
- out_valid, output, 1: one-cycle strobe, new coordinates present.
- out_x, output, OUT_W: display x.
- out_y, output, OUT_W: display y.
- locked, output, 1: window full and tracking.
- lost, output, 1: target-loss timeout reached.

Behaviour:
- Reset values:
  - out_valid=0, out_x=0, out_y=0, locked=0, lost=1.
  - sum registers, count, write pointer, reject counter and timeout counter all 0.
- Accepted sample: in_valid=1 and in_found=1 and not rejected.
- Pipeline:
  - Stage 1 updates window and sums.
  - Stage 2 registers the scaled result.
  - out_valid fires exactly 2 cycles after the in_valid of an accepted sample that produces output.
  - No backpressure; in_valid may be asserted on every cycle.
- Window:
  - Circular buffer of 2^LOG2_WIN x/y pairs.
  - Sums are IN_W+LOG2_WIN bits wide.
  - While count < 2^N: sum += new, count++, no out_valid in averaged mode.
  - Once full: sum += new - buf[wr_ptr]; wr_ptr wraps modulo 2^N.
  - avg = sum >> LOG2_WIN (truncating).
  - locked=1 from the cycle count reaches 2^N until the next flush.
- Flush: count=0, sum=0, locked=0. The buffer contents are not cleared; they are ignored until overwritten.
- Outlier rejection:
  - Only when locked and avg_en=1.
  - Reject if |in - avg| > JUMP_MAX on either axis; comparison is strictly greater.
  - A rejected sample leaves the window untouched and increments reject_cnt.
  - An accepted sample clears reject_cnt.
  - When reject_cnt reaches REJECT_LIMIT: flush, then the next found sample starts re-acquire and is not rejected.
- Timeout:
  - Counter increments every cycle and clears on an accepted or rejected found sample.
  - in_valid with in_found=0 does not clear it.
  - At LOST_TIMEOUT: lost=1, flush, counter saturates.
  - lost clears on the next accepted sample.
  - out_x and out_y hold their last values while lost.
- Pass-through (avg_en=0): every found sample is scaled directly, no rejection, locked=1 after the first found sample.
- avg_en toggle: flush on the cycle of change. An in_valid arriving in the same cycle is treated as the first sample of the new mode.
- Scaling:
  - scaled = (v * MUL) >> SHIFT, using a full-width product.
  - Clamp to DST-1, then mirror x if MIRROR_X=1.
  - A result below 0 after mirroring is floored to 0.
- Reset mid-operation aborts any in-flight sample; no out_valid is produced for it.

Decomposition:
- Package track_pos_pkg holds:
  - Default scale constants.
  - Function clog2.
  - Function abs_diff.
- Sub-module pos_scale handles multiply, shift, clamp and optional mirror for one axis.
  - Parameters: IN_W, OUT_W, MUL, SHIFT, DST, MIRROR.
  - Registered output.
  - Instantiated twice.
- Window, rejection and timeout logic live in track_pos_filter itself.

Test Plan:
- Pass-through, defaults:
  - (160,120), avg_en=0 → out_valid 2 cycles later, out_x=1279-640=639, out_y=(120*273)>>6=511.
  - (319,239) → out_x=3, out_y=1019.
- Averaged, LOG2_WIN=2:
  - Samples x=10,20,30,40 → no output for the first 3; 4th gives avg 25, out_x=1279-100=1179, locked=1.
  - 5th sample x=50 → avg 35.
- Outlier:
  - Locked at avg x=100; one sample x=141 → rejected, outputs unchanged.
  - x=140 → accepted.
  - 8 consecutive x=300 → flush, locked=0.
- Timeout, LOST_TIMEOUT=100:
  - No found samples for 100 cycles → lost=1, locked=0, outputs held.
  - in_found=0 strobes during the wait do not delay lost.
- Reset and mode:
  - resetn low between in_valid and out_valid → no out_valid, all outputs at reset values.
  - Toggle avg_en while locked → locked=0 next cycle.

Source files
------------

// File: rtl/track_pos_pkg.sv
// Shared constants and helpers for the tracked-position conditioning path.
package track_pos_pkg;
    localparam int X_MUL_DEF   = 4;
    localparam int X_SHIFT_DEF = 0;
    localparam int Y_MUL_DEF   = 273;
    localparam int Y_SHIFT_DEF = 6;
    localparam int X_DST_DEF   = 1280;
    localparam int Y_DST_DEF   = 1024;

    // Bits needed to index v distinct values; use clog2(n+1) to hold the value n.
    function automatic int clog2(input int v);
        int r = 0;
        longint t = 1;
        while (t < longint'(v)) begin
            t = t << 1;
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
        return (a > b) ? (a - b) : (b - a);
    endfunction
endpackage

// File: rtl/track_pos_filter_if.sv
// Sample-in / coordinate-out bundle between capture and the game path.
interface track_pos_filter_if #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 12
);
    logic             in_valid;
    logic             in_found;
    logic [IN_W-1:0]  in_x;
    logic [IN_W-1:0]  in_y;
    logic             out_valid;
    logic [OUT_W-1:0] out_x;
    logic [OUT_W-1:0] out_y;

    modport master (output in_valid, in_found, in_x, in_y,
                    input  out_valid, out_x, out_y);
    modport slave  (input  in_valid, in_found, in_x, in_y,
                    output out_valid, out_x, out_y);
endinterface

// File: rtl/pos_scale.sv
// One-axis scale (multiply, shift), clamp to the raster and optional mirror; registered.
module pos_scale import track_pos_pkg::*; #(
    parameter int IN_W   = 9,
    parameter int OUT_W  = 12,
    parameter int MUL    = 4,
    parameter int SHIFT  = 0,
    parameter int DST    = 1280,
    parameter bit MIRROR = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [IN_W-1:0]  v,
    output logic [OUT_W-1:0] out
);
    localparam int PROD_W = IN_W + clog2(MUL + 1);
    localparam int PW     = (PROD_W > OUT_W) ? PROD_W : OUT_W;
    localparam logic [PW-1:0] LIM = PW'(DST - 1);

    logic [PW-1:0]    prod, scaled, clamped;
    logic [OUT_W-1:0] out_d, out_q;

    // Clamp precedes the mirror, so LIM - clamped can never go below zero.
    always_comb begin
        prod    = PW'(v) * PW'(MUL);
        scaled  = prod >> SHIFT;
        clamped = (scaled > LIM) ? LIM : scaled;
        out_d   = out_q;
        if (en) out_d = MIRROR ? OUT_W'(LIM - clamped) : OUT_W'(clamped);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) out_q <= '0;
        else         out_q <= out_d;
    end

    assign out = out_q;
endmodule

// File: rtl/track_pos_filter.sv
// Boxcar smoothing, outlier rejection and loss timeout for blob centroids, then
// per-axis scaling to the display raster. Output appears two cycles after the sample.
module track_pos_filter import track_pos_pkg::*; #(
    parameter int IN_W         = 9,
    parameter int OUT_W        = 12,
    parameter int LOG2_WIN     = 4,
    parameter int X_MUL        = X_MUL_DEF,
    parameter int X_SHIFT      = X_SHIFT_DEF,
    parameter int Y_MUL        = Y_MUL_DEF,
    parameter int Y_SHIFT      = Y_SHIFT_DEF,
    parameter int X_DST        = X_DST_DEF,
    parameter int Y_DST        = Y_DST_DEF,
    parameter bit MIRROR_X     = 1'b1,
    parameter int JUMP_MAX     = 40,
    parameter int REJECT_LIMIT = 8,
    parameter int LOST_TIMEOUT = 2500000
) (
    input  logic               clk,
    input  logic               resetn,
    track_pos_filter_if.slave  io,
    input  logic               avg_en,
    output logic               locked,
    output logic               lost
);
    localparam int WIN    = 1 << LOG2_WIN;
    localparam int SUM_W  = IN_W + LOG2_WIN;
    localparam int CNT_W  = LOG2_WIN + 1;
    localparam int PTR_W  = (LOG2_WIN > 0) ? LOG2_WIN : 1;
    localparam int REJ_W  = clog2(REJECT_LIMIT + 1);
    localparam int TO_W   = clog2(LOST_TIMEOUT + 1);
    localparam int STAGES = 2;
    localparam logic [TO_W-1:0]  TO_MAX = TO_W'(LOST_TIMEOUT);
    localparam logic [TO_W-1:0]  TO_HIT = TO_W'(LOST_TIMEOUT - 1);
    localparam logic [REJ_W-1:0] REJ_HIT = REJ_W'(REJECT_LIMIT - 1);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(WIN);

    logic [WIN-1:0][IN_W-1:0] buf_x_q, buf_x_d, buf_y_q, buf_y_d;
    logic [SUM_W-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [REJ_W-1:0] rej_q, rej_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             locked_q, locked_d, lost_q, lost_d, mode_q, mode_d;
    logic [IN_W-1:0]  val_x_q, val_x_d, val_y_q, val_y_d;
    logic [STAGES:1]  vld_pipe_q, vld_pipe_d;
    logic             vld_s0, found, reject;
    logic [IN_W-1:0]  avg_x, avg_y, old_x, old_y;

    always_comb begin
        buf_x_d  = buf_x_q;  buf_y_d  = buf_y_q;
        sum_x_d  = sum_x_q;  sum_y_d  = sum_y_q;
        cnt_d    = cnt_q;    wr_ptr_d = wr_ptr_q;
        rej_d    = rej_q;    to_d     = to_q;
        locked_d = locked_q; lost_d   = lost_q;
        val_x_d  = val_x_q;  val_y_d  = val_y_q;
        mode_d   = avg_en;
        vld_s0   = 1'b0;
        old_x    = '0;       old_y    = '0;
        found    = io.in_valid && io.in_found;
        avg_x    = IN_W'(sum_x_q >> LOG2_WIN);
        avg_y    = IN_W'(sum_y_q >> LOG2_WIN);

        // Mode change empties the window first; a same-cycle sample then starts the new mode.
        if (avg_en != mode_q) begin
            cnt_d = '0; sum_x_d = '0; sum_y_d = '0; locked_d = 1'b0; rej_d = '0;
        end

        reject = found && avg_en && locked_d &&
                 ((abs_diff(32'(io.in_x), 32'(avg_x)) > 32'(JUMP_MAX)) ||
                  (abs_diff(32'(io.in_y), 32'(avg_y)) > 32'(JUMP_MAX)));

        if (found)             to_d = '0;
        else if (to_q != TO_MAX) to_d = to_q + 1'b1;

        if (reject) begin
            if (rej_q == REJ_HIT) begin
                cnt_d = '0; sum_x_d = '0; sum_y_d = '0; locked_d = 1'b0; rej_d = '0;
            end else begin
                rej_d = rej_q + 1'b1;
            end
        end else if (found) begin
            rej_d  = '0;
            lost_d = 1'b0;
            if (avg_en) begin
                if (cnt_d == FULL) begin
                    old_x = buf_x_q[wr_ptr_q];
                    old_y = buf_y_q[wr_ptr_q];
                end else begin
                    cnt_d = cnt_d + 1'b1;
                end
                sum_x_d = sum_x_d + SUM_W'(io.in_x) - SUM_W'(old_x);
                sum_y_d = sum_y_d + SUM_W'(io.in_y) - SUM_W'(old_y);
                buf_x_d[wr_ptr_q] = io.in_x;
                buf_y_d[wr_ptr_q] = io.in_y;
                wr_ptr_d = (LOG2_WIN == 0) ? '0 : wr_ptr_q + 1'b1;
                locked_d = (cnt_d == FULL);
                vld_s0   = locked_d;
                val_x_d  = IN_W'(sum_x_d >> LOG2_WIN);
                val_y_d  = IN_W'(sum_y_d >> LOG2_WIN);
            end else begin
                locked_d = 1'b1;
                vld_s0   = 1'b1;
                val_x_d  = io.in_x;
                val_y_d  = io.in_y;
            end
        end else if (to_q == TO_HIT) begin
            lost_d = 1'b1;
            cnt_d = '0; sum_x_d = '0; sum_y_d = '0; locked_d = 1'b0; rej_d = '0;
        end

        vld_pipe_d = {vld_pipe_q[STAGES-1:1], vld_s0};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_x_q <= '0;  buf_y_q <= '0;
            sum_x_q <= '0;  sum_y_q <= '0;
            cnt_q <= '0;    wr_ptr_q <= '0;
            rej_q <= '0;    to_q <= '0;
            locked_q <= 1'b0; lost_q <= 1'b1; mode_q <= 1'b0;
            val_x_q <= '0;  val_y_q <= '0;
            vld_pipe_q <= '0;
        end else begin
            buf_x_q <= buf_x_d;  buf_y_q <= buf_y_d;
            sum_x_q <= sum_x_d;  sum_y_q <= sum_y_d;
            cnt_q <= cnt_d;      wr_ptr_q <= wr_ptr_d;
            rej_q <= rej_d;      to_q <= to_d;
            locked_q <= locked_d; lost_q <= lost_d; mode_q <= mode_d;
            val_x_q <= val_x_d;  val_y_q <= val_y_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    pos_scale #(.IN_W(IN_W), .OUT_W(OUT_W), .MUL(X_MUL), .SHIFT(X_SHIFT),
                .DST(X_DST), .MIRROR(MIRROR_X)) u_scale_x (
        .clk(clk), .resetn(resetn), .en(vld_pipe_q[1]), .v(val_x_q), .out(io.out_x));
    pos_scale #(.IN_W(IN_W), .OUT_W(OUT_W), .MUL(Y_MUL), .SHIFT(Y_SHIFT),
                .DST(Y_DST), .MIRROR(1'b0)) u_scale_y (
        .clk(clk), .resetn(resetn), .en(vld_pipe_q[1]), .v(val_y_q), .out(io.out_y));

    assign io.out_valid = vld_pipe_q[STAGES];
    assign locked       = locked_q;
    assign lost         = lost_q;
endmodule

// File: tb/tb_track_pos_filter.sv
// Randomised and directed bench for track_pos_filter against a queue-based window model.
module tb_track_pos_filter;
    localparam int WIN = 4, TO = 100, JMP = 40, RL = 8;

    logic clk = 1'b0, resetn = 1'b0, avg_en = 1'b0;
    logic locked, lost;

    track_pos_filter_if #(.IN_W(9), .OUT_W(12)) io ();

    track_pos_filter #(.LOG2_WIN(2), .LOST_TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .io(io.slave),
        .avg_en(avg_en), .locked(locked), .lost(lost));

    always #5 clk = ~clk;

    int  q_x[$], q_y[$];
    bit  m_en_prev, m_locked, m_lost;
    int  m_rej, m_idle;
    bit  pend_v, exp_valid;
    int  pend_x, pend_y, exp_x, exp_y;
    int  n_chk = 0, n_fail = 0;

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction
    function automatic int sc_x(input int v);
        int s = v * 4;
        if (s > 1279) s = 1279;
        return 1279 - s;
    endfunction
    function automatic int sc_y(input int v);
        int s = (v * 273) / 64;
        return (s > 1023) ? 1023 : s;
    endfunction

    task automatic model_reset();
        q_x.delete(); q_y.delete();
        m_en_prev = 0; m_locked = 0; m_lost = 1; m_rej = 0; m_idle = 0;
        pend_v = 0; exp_valid = 0; exp_x = 0; exp_y = 0;
    endtask

    task automatic m_flush();
        q_x.delete(); q_y.delete(); m_locked = 0; m_rej = 0;
    endtask

    // Apply one cycle of input to both DUT and model; leaves expectations for the post-edge state.
    task automatic step(input bit v, input bit f, input int x, input int y, input bit en);
        bit prod = 0, rej = 0;
        int ox = 0, oy = 0, ax = 0, ay = 0;
        io.in_valid = v; io.in_found = f; io.in_x = 9'(x); io.in_y = 9'(y); avg_en = en;
        if (en != m_en_prev) m_flush();
        m_en_prev = en;
        if (v && f) begin
            m_idle = 0;
            if (en && m_locked) begin
                foreach (q_x[i]) begin ax += q_x[i]; ay += q_y[i]; end
                ax /= WIN; ay /= WIN;
                rej = (iabs(x - ax) > JMP) || (iabs(y - ay) > JMP);
            end
            if (rej) begin
                m_rej++;
                if (m_rej == RL) m_flush();
            end else begin
                m_rej = 0; m_lost = 0;
                if (en) begin
                    q_x.push_back(x); q_y.push_back(y);
                    if (q_x.size() > WIN) begin void'(q_x.pop_front()); void'(q_y.pop_front()); end
                    if (q_x.size() == WIN) begin
                        m_locked = 1; prod = 1;
                        foreach (q_x[i]) begin ox += q_x[i]; oy += q_y[i]; end
                        ox /= WIN; oy /= WIN;
                    end
                end else begin
                    m_locked = 1; prod = 1; ox = x; oy = y;
                end
            end
        end else if (m_idle < TO) begin
            m_idle++;
            if (m_idle == TO) begin m_lost = 1; m_flush(); end
        end
        @(posedge clk); #1;
        exp_valid = pend_v;
        if (pend_v) begin exp_x = pend_x; exp_y = pend_y; end
        pend_v = prod;
        if (prod) begin pend_x = sc_x(ox); pend_y = sc_y(oy); end
        io.in_valid = 1'b0; io.in_found = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        io.in_valid = 0; io.in_found = 0; io.in_x = 0; io.in_y = 0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0d want 0", io.out_valid); end
        n_chk++; if (io.out_x !== 12'd0) begin n_fail++; $display("FAIL reset_out_x: got %0d want 0", io.out_x); end
        n_chk++; if (io.out_y !== 12'd0) begin n_fail++; $display("FAIL reset_out_y: got %0d want 0", io.out_y); end
        n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0d want 0", locked); end
        n_chk++; if (lost !== 1'b1) begin n_fail++; $display("FAIL reset_lost: got %0d want 1", lost); end
        @(negedge clk); resetn = 1'b1;
    endtask

    task automatic test_passthrough();
        step(1, 1, 160, 120, 0);
        n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL pass_locked: got %0d want 1", locked); end
        step(0, 0, 0, 0, 0);
        n_chk++; if ({io.out_valid, io.out_x, io.out_y} !== {1'b1, 12'd639, 12'd511}) begin
            n_fail++; $display("FAIL pass_160_120: got v=%0d x=%0d y=%0d want v=1 x=639 y=511", io.out_valid, io.out_x, io.out_y); end
        step(1, 1, 319, 239, 0);
        step(0, 0, 0, 0, 0);
        n_chk++; if ({io.out_valid, io.out_x, io.out_y} !== {1'b1, 12'd3, 12'd1019}) begin
            n_fail++; $display("FAIL pass_319_239: got v=%0d x=%0d y=%0d want v=1 x=3 y=1019", io.out_valid, io.out_x, io.out_y); end
        for (int i = 0; i < 30; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, $urandom_range(0, 511), $urandom_range(0, 511), 0);
            n_chk++;
            if ({io.out_valid, io.out_x, io.out_y, locked, lost} !== {exp_valid, 12'(exp_x), 12'(exp_y), m_locked, m_lost}) begin
                n_fail++;
                $display("FAIL pass_rand %0d: got v=%0d x=%0d y=%0d lk=%0d lo=%0d want v=%0d x=%0d y=%0d lk=%0d lo=%0d", i,
                         io.out_valid, io.out_x, io.out_y, locked, lost, exp_valid, exp_x, exp_y, m_locked, m_lost);
            end
        end
    endtask

    task automatic test_average();
        int xs[5] = '{10, 20, 30, 40, 50};
        for (int i = 0; i < 5; i++) begin
            step(1, 1, xs[i], 100, 1);
            n_chk++;
            if ({io.out_valid, io.out_x, io.out_y, locked, lost} !== {exp_valid, 12'(exp_x), 12'(exp_y), m_locked, m_lost}) begin
                n_fail++;
                $display("FAIL avg_seq %0d: got v=%0d x=%0d lk=%0d want v=%0d x=%0d lk=%0d", i,
                         io.out_valid, io.out_x, locked, exp_valid, exp_x, m_locked);
            end
            if (i == 2) begin
                n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL avg_not_locked_yet: got %0d want 0", locked); end
            end
            if (i == 3) begin
                n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL avg_locked: got %0d want 1", locked); end
            end
            if (i == 4) begin
                n_chk++; if ({io.out_valid, io.out_x, io.out_y} !== {1'b1, 12'd1179, 12'd426}) begin
                    n_fail++; $display("FAIL avg_25: got v=%0d x=%0d y=%0d want v=1 x=1179 y=426", io.out_valid, io.out_x, io.out_y); end
            end
        end
        step(0, 0, 0, 0, 1);
        n_chk++; if ({io.out_valid, io.out_x} !== {1'b1, 12'd1139}) begin
            n_fail++; $display("FAIL avg_35: got v=%0d x=%0d want v=1 x=1139", io.out_valid, io.out_x); end
    endtask

    task automatic test_outlier();
        step(0, 0, 0, 0, 0);
        repeat (4) step(1, 1, 100, 100, 1);
        repeat (2) step(0, 0, 0, 0, 1);
        step(1, 1, 141, 100, 1);
        repeat (2) step(0, 0, 0, 0, 1);
        n_chk++; if ({io.out_valid, io.out_x, locked} !== {1'b0, 12'd879, 1'b1}) begin
            n_fail++; $display("FAIL outlier_141_rejected: got v=%0d x=%0d lk=%0d want v=0 x=879 lk=1", io.out_valid, io.out_x, locked); end
        step(1, 1, 140, 100, 1);
        step(0, 0, 0, 0, 1);
        n_chk++; if ({io.out_valid, io.out_x} !== {1'b1, 12'd839}) begin
            n_fail++; $display("FAIL outlier_140_accepted: got v=%0d x=%0d want v=1 x=839", io.out_valid, io.out_x); end
        for (int i = 1; i <= RL; i++) begin
            step(1, 1, 300, 100, 1);
            n_chk++;
            if ({io.out_valid, io.out_x, io.out_y, locked, lost} !== {exp_valid, 12'(exp_x), 12'(exp_y), m_locked, m_lost}) begin
                n_fail++;
                $display("FAIL outlier_burst %0d: got v=%0d x=%0d lk=%0d want v=%0d x=%0d lk=%0d", i,
                         io.out_valid, io.out_x, locked, exp_valid, exp_x, m_locked);
            end
            if (i == RL - 1) begin
                n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL outlier_7_still_locked: got %0d want 1", locked); end
            end
        end
        n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL outlier_flush: got locked=%0d want 0", locked); end
        step(1, 1, 300, 100, 1);
        n_chk++; if ({io.out_valid, locked} !== {exp_valid, m_locked}) begin
            n_fail++; $display("FAIL outlier_reacquire: got v=%0d lk=%0d want v=%0d lk=%0d", io.out_valid, locked, exp_valid, m_locked); end
    endtask

    task automatic test_timeout();
        repeat (4) step(1, 1, 300, 100, 1);
        n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL to_locked: got %0d want 1", locked); end
        for (int i = 1; i <= TO; i++) begin
            step(i % 7 == 0, 0, 0, 0, 1);
            n_chk++;
            if ({io.out_valid, io.out_x, io.out_y, locked, lost} !== {exp_valid, 12'(exp_x), 12'(exp_y), m_locked, m_lost}) begin
                n_fail++;
                $display("FAIL to_wait %0d: got v=%0d x=%0d lk=%0d lo=%0d want v=%0d x=%0d lk=%0d lo=%0d", i,
                         io.out_valid, io.out_x, locked, lost, exp_valid, exp_x, m_locked, m_lost);
            end
            if (i == TO - 1) begin
                n_chk++; if (lost !== 1'b0) begin n_fail++; $display("FAIL to_early: got lost=%0d want 0", lost); end
            end
        end
        n_chk++; if ({lost, locked, io.out_x, io.out_y} !== {1'b1, 1'b0, 12'd79, 12'd426}) begin
            n_fail++; $display("FAIL to_lost: got lo=%0d lk=%0d x=%0d y=%0d want lo=1 lk=0 x=79 y=426", lost, locked, io.out_x, io.out_y); end
        step(1, 1, 300, 100, 1);
        n_chk++; if (lost !== 1'b0) begin n_fail++; $display("FAIL to_recover: got lost=%0d want 0", lost); end
    endtask

    task automatic test_mode_toggle();
        step(1, 1, 50, 60, 0);
        n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL toggle_pre: got locked=%0d want 1", locked); end
        step(0, 0, 0, 0, 1);
        n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL toggle_flush: got locked=%0d want 0", locked); end
    endtask

    task automatic test_random();
        bit en = 1;
        int cx = 200, cy = 200, x, y;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) en = ~en;
            if ($urandom_range(0, 39) == 0) begin cx = $urandom_range(60, 450); cy = $urandom_range(60, 450); end
            x = cx + int'($urandom_range(0, 120)) - 60;
            y = cy + int'($urandom_range(0, 120)) - 60;
            if (x < 0) x = 0; if (x > 511) x = 511;
            if (y < 0) y = 0; if (y > 511) y = 511;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 85, x, y, en);
            n_chk++;
            if ({io.out_valid, io.out_x, io.out_y, locked, lost} !== {exp_valid, 12'(exp_x), 12'(exp_y), m_locked, m_lost}) begin
                n_fail++;
                $display("FAIL rand %0d: got v=%0d x=%0d y=%0d lk=%0d lo=%0d want v=%0d x=%0d y=%0d lk=%0d lo=%0d", i,
                         io.out_valid, io.out_x, io.out_y, locked, lost, exp_valid, exp_x, exp_y, m_locked, m_lost);
            end
        end
    endtask

    task automatic test_reset_midflight();
        step(1, 1, 200, 200, 0);
        resetn = 1'b0;
        model_reset();
        @(posedge clk); #1;
        n_chk++; if ({io.out_valid, io.out_x, io.out_y, locked, lost} !== {1'b0, 12'd0, 12'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL midreset: got v=%0d x=%0d y=%0d lk=%0d lo=%0d want v=0 x=0 y=0 lk=0 lo=1",
                               io.out_valid, io.out_x, io.out_y, locked, lost); end
        @(negedge clk); resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0);
            n_chk++; if ({io.out_valid, io.out_x, lost} !== {1'b0, 12'd0, 1'b1}) begin
                n_fail++; $display("FAIL midreset_after %0d: got v=%0d x=%0d lo=%0d want v=0 x=0 lo=1", i, io.out_valid, io.out_x, lost); end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_average();
        test_outlier();
        test_timeout();
        test_mode_toggle();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
